gsim_param_solver: RTL and testbench

Parametrised Gauss-Seidel solver for the banded system A·x = b, where A is N×N with a fixed 7-point stencil: 20 on the diagonal, −13 at ±1, 6 at ±2, −1 at ±3. It is the next generation of the team's fixed 16-point GSIM engine. It adds configurable size and widths, valid/ready handshakes on both streams, and optional early termination on convergence. It sits between the b-vector stream source and the x-vector consumer.

---
 rtl/gsim_pkg.sv | 41 ++++
 rtl/gsim_row_calc.sv | 82 ++++++++
 rtl/gsim_param_solver.sv | 241 ++++++++++++++++++++++++
 tb/tb_gsim_param_solver.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gsim_pkg.sv
// ---------------------------------------------------------------------------
// gsim_pkg
// Shared definitions for the Gauss-Seidel banded solver:
//   - gsim_state_e : solver FSM states
//   - C0..C3       : stencil magnitudes (diag 20, -13 at +/-1, 6 at +/-2, -1 at +/-3)
//   - RECIP/RECIP_SH : fixed-point reciprocal of the diagonal (52429 / 2^20 ~ 1/20)
//   - sat_check()  : range test used to saturate a wide value to a signed width
// Optional feature macro used by the files importing this package:
//   GSIM_EARLY_EXIT_EN
// ---------------------------------------------------------------------------
package gsim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SOLVE = 2'd2,
        ST_DRAIN = 2'd3
    } gsim_state_e;

    localparam int C0 = 20;
    localparam int C1 = 13;
    localparam int C2 = 6;
    localparam int C3 = 1;

    localparam int RECIP    = 52429;
    localparam int RECIP_SH = 20;

    // Wide enough to hold any shifted product this block produces.
    localparam int SAT_W = 128;

    // Returns {above_max, below_min} for v against the signed range of width w.
    function automatic logic [1:0] sat_check(input logic signed [SAT_W-1:0] v,
                                             input int                      w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
        lo = -hi - SAT_W'(1);
        sat_check = {v > hi, v < lo};
    endfunction

endpackage

// File: rtl/gsim_row_calc.sv
// ---------------------------------------------------------------------------
// gsim_row_calc
// One Gauss-Seidel row update, split over two cycles:
//   cycle A (i_load=1): register numerator
//       s = (b<<<FRAC) + 13(x[i-1]+x[i+1]) - 6(x[i-2]+x[i+2]) + (x[i-3]+x[i+3])
//   cycle B: x_new = sat((s*52429) >>> 20), combinational from the register.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   i_load              capture numerator this cycle
//   i_b                 b[i]
//   i_xm1..i_xm3        x[i-1..i-3] (already-updated values, 0 if out of range)
//   i_xp1..i_xp3        x[i+1..i+3] (previous-sweep values, 0 if out of range)
//   i_x_old, o_abs_delta  only with GSIM_EARLY_EXIT_EN: |x_new - x_old|
//   o_x_new             saturated new x[i]
// ---------------------------------------------------------------------------
module gsim_row_calc
    import gsim_pkg::*;
#(
    parameter int B_W  = 16,
    parameter int X_W  = 32,
    parameter int FRAC = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_load,
    input  logic signed [B_W-1:0] i_b,
    input  logic signed [X_W-1:0] i_xm1,
    input  logic signed [X_W-1:0] i_xp1,
    input  logic signed [X_W-1:0] i_xm2,
    input  logic signed [X_W-1:0] i_xp2,
    input  logic signed [X_W-1:0] i_xm3,
    input  logic signed [X_W-1:0] i_xp3,
`ifdef GSIM_EARLY_EXIT_EN
    input  logic signed [X_W-1:0] i_x_old,
    output logic        [X_W:0]   o_abs_delta,
`endif
    output logic signed [X_W-1:0] o_x_new
);

    localparam int NUM_W  = X_W + 6;
    localparam int PROD_W = X_W + 22;

    logic signed [NUM_W-1:0]  w_b_sh;
    logic signed [NUM_W-1:0]  w_n1;
    logic signed [NUM_W-1:0]  w_n2;
    logic signed [NUM_W-1:0]  w_n3;
    logic signed [NUM_W-1:0]  w_num;
    logic signed [NUM_W-1:0]  r_num;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_shifted;
    logic        [1:0]        w_sat;

    assign w_b_sh = NUM_W'(i_b) <<< FRAC;
    assign w_n1   = NUM_W'(i_xm1) + NUM_W'(i_xp1);
    assign w_n2   = NUM_W'(i_xm2) + NUM_W'(i_xp2);
    assign w_n3   = NUM_W'(i_xm3) + NUM_W'(i_xp3);
    assign w_num  = w_b_sh + NUM_W'(C1) * w_n1 - NUM_W'(C2) * w_n2 + NUM_W'(C3) * w_n3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_num <= '0;
        end else if (i_load) begin
            r_num <= w_num;
        end
    end

    // Multiply by 52429/2^20 ~ 1/20; arithmetic shift floors negative values.
    assign w_prod    = PROD_W'(r_num) * PROD_W'(RECIP);
    assign w_shifted = w_prod >>> RECIP_SH;
    assign w_sat     = sat_check(SAT_W'(w_shifted), X_W);

    assign o_x_new = w_sat[1] ? {1'b0, {(X_W-1){1'b1}}} :
                     w_sat[0] ? {1'b1, {(X_W-1){1'b0}}} :
                     w_shifted[X_W-1:0];

`ifdef GSIM_EARLY_EXIT_EN
    logic signed [X_W:0] w_diff;
    assign w_diff      = (X_W+1)'(o_x_new) - (X_W+1)'(i_x_old);
    assign o_abs_delta = w_diff[X_W] ? -w_diff : w_diff;
`endif

endmodule

// File: rtl/gsim_param_solver.sv
// ---------------------------------------------------------------------------
// gsim_param_solver
// Gauss-Seidel solver for A x = b with the banded stencil
// (-1, 6, -13, 20, -13, 6, -1). b streams in, x (Q(X_W-FRAC).FRAC) streams out.
// Optional macro: GSIM_EARLY_EXIT_EN -- stop after a sweep whose largest
// |x_new - x_old| is <= TOL and flag it on `converged`.
// Handshakes: a beat transfers on a rising edge where valid && ready are both
// high; a valid source holds its data stable until that edge.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   in_valid/in_ready     b stream (index order 0..N-1), b_in
//   out_valid/out_ready   x stream (index order 0..N-1), x_out
//   busy                  high while sweeping
//   iter_used             sweeps run for the last solve
//   converged             last solve ended on tolerance
//   dbg_state             current FSM state (gsim_state_e encoding)
// Latency: out_valid rises 2N*k+1 cycles after the last b beat is accepted;
// the extra cycle primes the registered x_out.
// ---------------------------------------------------------------------------
module gsim_param_solver
    import gsim_pkg::*;
#(
    parameter int N        = 16,
    parameter int B_W      = 16,
    parameter int X_W      = 32,
    parameter int FRAC     = 16,
    parameter int MAX_ITER = 72,
    parameter int TOL      = 16,
    parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [B_W-1:0]    b_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [X_W-1:0]    x_out,
    output logic              busy,
    output logic [ITER_W-1:0] iter_used,
    output logic              converged,
    output logic [1:0]        dbg_state
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    gsim_state_e r_state;
    gsim_state_e w_next;

    logic        [IDX_W-1:0]  r_idx;     // load index, row index, or drain index
    logic                     r_phase;   // 0: row cycle A, 1: row cycle B
    logic signed [B_W-1:0]    r_b [N];
    logic signed [X_W-1:0]    r_x [N];
    logic        [ITER_W-1:0] r_iter;
    logic                     r_conv;
    logic                     r_out_valid;
    logic        [X_W-1:0]    r_x_out;

    logic        [IDX_W:0]    w_lo_k [3];
    logic        [IDX_W:0]    w_hi_k [3];
    logic signed [X_W-1:0]    w_lo [3];
    logic signed [X_W-1:0]    w_hi [3];
    logic signed [X_W-1:0]    w_x_new;
    logic                     w_in_acc;
    logic                     w_out_acc;
    logic                     w_row_b;
    logic                     w_sweep_end;
    logic                     w_max_hit;
    logic                     w_tol_hit;
    logic                     w_exit;

    assign w_in_acc    = in_valid && ((r_state == ST_IDLE) || (r_state == ST_LOAD));
    assign w_out_acc   = (r_state == ST_DRAIN) && r_out_valid && out_ready;
    assign w_row_b     = (r_state == ST_SOLVE) && r_phase;
    assign w_sweep_end = w_row_b && (r_idx == LAST);
    assign w_max_hit   = (r_iter == ITER_W'(MAX_ITER - 1));

    // Neighbour fetch: an extra MSB on the index catches underflow, and
    // anything outside 0..N-1 contributes zero.
    always_comb begin
        for (int d = 0; d < 3; d++) begin
            w_lo_k[d] = {1'b0, r_idx} - (IDX_W+1)'(d + 1);
            w_hi_k[d] = {1'b0, r_idx} + (IDX_W+1)'(d + 1);
            w_lo[d]   = '0;
            w_hi[d]   = '0;
            if (!w_lo_k[d][IDX_W]) begin
                w_lo[d] = r_x[w_lo_k[d][IDX_W-1:0]];
            end
            if (w_hi_k[d] < (IDX_W+1)'(N)) begin
                w_hi[d] = r_x[w_hi_k[d][IDX_W-1:0]];
            end
        end
    end

`ifdef GSIM_EARLY_EXIT_EN
    logic [X_W:0] w_abs_delta;
    logic [X_W:0] w_sweep_max;
    logic [X_W:0] r_max_delta;

    // Running max includes the row being written this cycle.
    assign w_sweep_max = (w_abs_delta > r_max_delta) ? w_abs_delta : r_max_delta;
    assign w_tol_hit   = (w_sweep_max <= (X_W+1)'(TOL));
    assign w_exit      = w_max_hit || w_tol_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_max_delta <= '0;
        end else if (w_row_b) begin
            r_max_delta <= w_sweep_end ? '0 : w_sweep_max;
        end
    end
`else
    assign w_tol_hit = 1'b0;
    assign w_exit    = w_max_hit;
`endif

    gsim_row_calc #(
        .B_W  (B_W),
        .X_W  (X_W),
        .FRAC (FRAC)
    ) u_row (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      ((r_state == ST_SOLVE) && !r_phase),
        .i_b         (r_b[r_idx]),
        .i_xm1       (w_lo[0]),
        .i_xp1       (w_hi[0]),
        .i_xm2       (w_lo[1]),
        .i_xp2       (w_hi[1]),
        .i_xm3       (w_lo[2]),
        .i_xp3       (w_hi[2]),
`ifdef GSIM_EARLY_EXIT_EN
        .i_x_old     (r_x[r_idx]),
        .o_abs_delta (w_abs_delta),
`endif
        .o_x_new     (w_x_new)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid) w_next = ST_LOAD;
            ST_LOAD:  if (in_valid && (r_idx == LAST)) w_next = ST_SOLVE;
            ST_SOLVE: if (w_sweep_end && w_exit) w_next = ST_DRAIN;
            ST_DRAIN: if (w_out_acc && (r_idx == LAST)) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx       <= '0;
            r_phase     <= 1'b0;
            r_iter      <= '0;
            r_conv      <= 1'b0;
            r_out_valid <= 1'b0;
            r_x_out     <= '0;
            for (int k = 0; k < N; k++) begin
                r_b[k] <= '0;
                r_x[k] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_in_acc) begin
                        r_b[0] <= b_in;
                        r_idx  <= IDX_W'(1);
                        r_iter <= '0;
                        r_conv <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_in_acc) begin
                        r_b[r_idx] <= b_in;
                        if (r_idx == LAST) begin
                            r_idx   <= '0;
                            r_phase <= 1'b0;
                            for (int k = 0; k < N; k++) begin
                                r_x[k] <= '0;
                            end
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                ST_SOLVE: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_x[r_idx] <= w_x_new;
                        if (r_idx == LAST) begin
                            r_idx  <= '0;
                            r_iter <= r_iter + ITER_W'(1);
                            if (w_exit) begin
                                r_conv <= w_tol_hit;
                            end
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // First DRAIN cycle loads x[0] into the output register.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_x_out     <= r_x[0];
                        r_idx       <= '0;
                    end else if (out_ready) begin
                        if (r_idx == LAST) begin
                            r_out_valid <= 1'b0;
                            r_idx       <= '0;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_x_out <= r_x[r_idx + IDX_W'(1)];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE) || (r_state == ST_LOAD);
    assign busy      = (r_state == ST_SOLVE);
    assign out_valid = r_out_valid;
    assign x_out     = r_x_out;
    assign iter_used = r_iter;
    assign converged = r_conv;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_gsim_param_solver.sv
// ---------------------------------------------------------------------------
// tb_gsim_param_solver
// Table of solve problems (b vector, input gap pattern, output ready pattern,
// expected sweeps/converged/x) generated up front from a plain-arithmetic
// Gauss-Seidel model, then applied in a loop. A hand-written sequence covers
// reset asserted mid-solve. Follows GSIM_EARLY_EXIT_EN like the design.
// ---------------------------------------------------------------------------
module tb_gsim_param_solver;

    localparam int N        = 16;
    localparam int B_W      = 16;
    localparam int X_W      = 32;
    localparam int FRAC     = 16;
    localparam int MAX_ITER = 72;
    localparam int TOL      = 16;
    localparam int ITER_W   = $clog2(MAX_ITER + 1);
    localparam int NVEC     = 5;
`ifdef GSIM_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [B_W-1:0]    b_in;
    logic              out_valid;
    logic              out_ready;
    logic [X_W-1:0]    x_out;
    logic              busy;
    logic [ITER_W-1:0] iter_used;
    logic              converged;
    logic [1:0]        dbg_state;

    always #5 clk = ~clk;

    gsim_param_solver #(
        .N(N), .B_W(B_W), .X_W(X_W), .FRAC(FRAC),
        .MAX_ITER(MAX_ITER), .TOL(TOL), .ITER_W(ITER_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .busy      (busy),
        .iter_used (iter_used),
        .converged (converged),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [X_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint m_b [N];
    longint m_x [N];
    int     m_iter;
    bit     m_conv;

    function automatic longint x_or_zero(input int k);
        if (k < 0 || k >= N) return 0;
        return m_x[k];
    endfunction

    task automatic model_solve();
        longint hi;
        longint lo;
        longint s;
        longint xn;
        longint d;
        longint maxd;
        hi = (longint'(1) << (X_W - 1)) - 1;
        lo = -hi - 1;
        for (int i = 0; i < N; i++) m_x[i] = 0;
        m_iter = 0;
        m_conv = 1'b0;
        for (int sw = 0; sw < MAX_ITER; sw++) begin
            maxd = 0;
            for (int i = 0; i < N; i++) begin
                s = m_b[i] * (longint'(1) << FRAC)
                    + 13 * (x_or_zero(i - 1) + x_or_zero(i + 1))
                    -  6 * (x_or_zero(i - 2) + x_or_zero(i + 2))
                    +      (x_or_zero(i - 3) + x_or_zero(i + 3));
                xn = (s * 52429) >>> 20;
                if (xn > hi) xn = hi;
                if (xn < lo) xn = lo;
                d = (xn > m_x[i]) ? xn - m_x[i] : m_x[i] - xn;
                if (d > maxd) maxd = d;
                m_x[i] = xn;
            end
            m_iter++;
            if (EARLY && maxd <= TOL) begin
                m_conv = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        int                          in_mode;   // 0 full rate, 1 pattern 1,0,0,1, 2 random
        int                          rdy_mode;  // 0 always ready, 1 toggle 1,0, 2 random
        logic [N-1:0][B_W-1:0]       b;
        int                          exp_iter;
        bit                          exp_conv;
        logic [N-1:0][X_W-1:0]       exp_x;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic fill_table();
        for (int v = 0; v < NVEC; v++) begin
            case (v)
                0: begin vecs[v].in_mode = 0; vecs[v].rdy_mode = 0; end
                1: begin vecs[v].in_mode = 1; vecs[v].rdy_mode = 1; end
                2: begin vecs[v].in_mode = 2; vecs[v].rdy_mode = 2; end
                3: begin vecs[v].in_mode = 0; vecs[v].rdy_mode = 1; end
                default: begin vecs[v].in_mode = 2; vecs[v].rdy_mode = 0; end
            endcase
            for (int i = 0; i < N; i++) begin
                case (v)
                    0: vecs[v].b[i] = '0;
                    1, 4: vecs[v].b[i] = B_W'(i + 1);
                    2: vecs[v].b[i] = B_W'($urandom_range(0, 4000)) - B_W'(2000);
                    default: vecs[v].b[i] = B_W'($urandom);
                endcase
                m_b[i] = longint'($signed(vecs[v].b[i]));
            end
            model_solve();
            vecs[v].exp_iter = m_iter;
            vecs[v].exp_conv = m_conv;
            for (int i = 0; i < N; i++) vecs[v].exp_x[i] = m_x[i][X_W-1:0];
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_load(input logic [N-1:0][B_W-1:0] bv, input int mode);
        int   k;
        int   cyc;
        logic v;
        logic acc;
        k   = 0;
        cyc = 0;
        while (k < N && cyc < 8 * N) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            b_in     = v ? bv[k] : B_W'($urandom);
            acc      = v && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                k++;
                if (k == N - 1) check("busy_before_last_beat", 64'(busy), 64'(0));
            end
        end
        in_valid = 1'b0;
        if (k < N) check("load_timeout_beats", 64'(k), 64'(N));
        check("solve_busy_after_last", 64'(busy), 64'(1));
        check("solve_in_ready_low", 64'(in_ready), 64'(0));
    endtask

    task automatic wait_output(input int exp_iter);
        int cyc;
        cyc = 0;
        // Garbage on the input stream while solving must be ignored.
        while (!out_valid && cyc < 2 * N * MAX_ITER + 20) begin
            in_valid = 1'($urandom_range(0, 1));
            b_in     = B_W'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check("first_out_latency", 64'(cyc), 64'(2 * N * exp_iter + 1));
    endtask

    task automatic drive_drain(input int mode);
        int             n;
        int             cyc;
        logic           r;
        logic           prev_stall;
        logic [X_W-1:0] prev_x;
        logic [X_W-1:0] exp;
        n          = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_x     = '0;
        while (n < N && cyc < 8 * N) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            if (prev_stall) check("x_out_stable_stall", 64'(x_out), 64'(prev_x));
            if (r && out_valid) begin
                exp = exp_q.pop_front();
                check("x_out_value", 64'(x_out), 64'(exp));
                n++;
            end
            prev_stall = out_valid && !r;
            prev_x     = x_out;
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        if (n < N) check("drain_timeout_beats", 64'(n), 64'(N));
        if (mode == 0) check("drain_cycles_ready", 64'(cyc), 64'(N));
        if (mode == 1) check("drain_cycles_toggle", 64'(cyc), 64'(2 * N - 1));
        check("post_drain_in_ready", 64'(in_ready), 64'(1));
        check("post_drain_out_valid", 64'(out_valid), 64'(0));
    endtask

    task automatic run_vec(input int v);
        drive_load(vecs[v].b, vecs[v].in_mode);
        wait_output(vecs[v].exp_iter);
        for (int i = 0; i < N; i++) exp_q.push_back(vecs[v].exp_x[i]);
        drive_drain(vecs[v].rdy_mode);
        check("iter_used", 64'(iter_used), 64'(vecs[v].exp_iter));
        check("converged", 64'(converged), 64'(vecs[v].exp_conv));
        exp_q.delete();
    endtask

    task automatic reset_mid_solve();
        logic [N-1:0][B_W-1:0] bv;
        for (int i = 0; i < N; i++) bv[i] = B_W'($urandom);
        drive_load(bv, 0);
        repeat (100) @(posedge clk);
        #1;
        check("rst_mid_busy_before", 64'(busy), 64'(1));
        reset_n = 1'b0;
        #2;
        check("rst_mid_in_ready", 64'(in_ready), 64'(1));
        check("rst_mid_out_valid", 64'(out_valid), 64'(0));
        check("rst_mid_iter_used", 64'(iter_used), 64'(0));
        check("rst_mid_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_in_ready_after", 64'(in_ready), 64'(1));
    endtask

    // ---------------- main ----------------
    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        b_in      = '0;
        out_ready = 1'b0;
        fill_table();
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_x_out", 64'(x_out), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_iter_used", 64'(iter_used), 64'(0));
        check("reset_converged", 64'(converged), 64'(0));
        check("reset_state_idle", 64'(dbg_state), 64'(0));
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < NVEC - 1; v++) run_vec(v);
        reset_mid_solve();
        run_vec(NVEC - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
